// File: rtl/y86_defs.sv
// Y86-64 shared definitions: instruction, ALU, condition and status codes,
// plus the M/W pipeline register payloads used by the memory stage.
package y86_defs;

    localparam int unsigned WORD_W  = 64;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned ICODE_W = 4;
    localparam int unsigned STAT_W  = 3;

    typedef enum logic [ICODE_W-1:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_XOR = 4'h3
    } alu_fn_e;

    typedef enum logic [3:0] {
        C_YES = 4'h0,
        C_LE  = 4'h1,
        C_L   = 4'h2,
        C_E   = 4'h3,
        C_NE  = 4'h4,
        C_GE  = 4'h5,
        C_G   = 4'h6
    } cond_e;

    typedef enum logic [STAT_W-1:0] {
        SAOK = 3'd1,
        SADR = 3'd2,
        SINS = 3'd3,
        SHLT = 3'd4
    } stat_e;

    localparam logic [REG_W-1:0] RNONE = 4'hF;

    typedef enum logic {
        DP_IDLE = 1'b0,
        DP_WAIT = 1'b1
    } dport_state_e;

    typedef struct packed {
        logic [STAT_W-1:0]  stat;
        logic [ICODE_W-1:0] icode;
        logic               cnd;
        logic [WORD_W-1:0]  val_e;
        logic [WORD_W-1:0]  val_a;
        logic [REG_W-1:0]   dst_e;
        logic [REG_W-1:0]   dst_m;
    } m_reg_t;

    typedef struct packed {
        logic [STAT_W-1:0]  stat;
        logic [ICODE_W-1:0] icode;
        logic [WORD_W-1:0]  val_e;
        logic [WORD_W-1:0]  val_m;
        logic [REG_W-1:0]   dst_e;
        logic [REG_W-1:0]   dst_m;
    } w_reg_t;

    localparam m_reg_t M_BUBBLE = '{
        stat: SAOK, icode: I_NOP, cnd: 1'b0,
        val_e: '0, val_a: '0, dst_e: RNONE, dst_m: RNONE
    };

    localparam w_reg_t W_BUBBLE = '{
        stat: SAOK, icode: I_NOP,
        val_e: '0, val_m: '0, dst_e: RNONE, dst_m: RNONE
    };

    function automatic logic is_mem_read(input logic [ICODE_W-1:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ) || (icode == I_RET);
    endfunction

    function automatic logic is_mem_write(input logic [ICODE_W-1:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_PUSHQ) || (icode == I_CALL);
    endfunction

    // POPQ and RET address through the stack pointer carried in valA.
    function automatic logic addr_from_val_a(input logic [ICODE_W-1:0] icode);
        return (icode == I_POPQ) || (icode == I_RET);
    endfunction

endpackage

// File: rtl/memory_access_dmem_port_fsm.sv
// Data-memory handshake: IDLE/WAIT sequencing, wait-cycle timeout and the
// request/stall strobes seen by the memory stage.
module dmem_port_fsm
    import y86_defs::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic access_i,
    input  logic ack_i,
    output logic req_c_o,
    output logic stall_c_o,
    output logic timeout_c_o
);

    localparam int unsigned       CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    dport_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= DP_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The IDLE cycle that raises an unacked request is the first wait cycle,
    // so WAIT aborts once TIMEOUT stalled cycles have elapsed in total.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_c_o     = 1'b0;
        timeout_c_o = 1'b0;
        unique case (state_q)
            DP_IDLE: begin
                if (access_i) begin
                    req_c_o = 1'b1;
                    if (!ack_i) begin
                        state_d = DP_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            DP_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    timeout_c_o = 1'b1;
                    state_d     = DP_IDLE;
                    cnt_d       = '0;
                end else begin
                    req_c_o = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (ack_i) begin
                        state_d = DP_IDLE;
                    end
                end
            end
            default: begin
                state_d = DP_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign stall_c_o = req_c_o && !ack_i;

endmodule

// File: rtl/memory_access.sv
// Y86-64 memory stage: M/W pipeline registers, address check, data-memory
// access through a req/ack port and the M-stage forwarding values.
module memory_access
    import y86_defs::*;
#(
    parameter int unsigned MEM_BYTES = 8192,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [2:0]  e_stat_i,
    input  logic [3:0]  e_icode_i,
    input  logic        e_cnd_i,
    input  logic [63:0] e_valE_i,
    input  logic [63:0] e_valA_i,
    input  logic [3:0]  e_dstE_i,
    input  logic [3:0]  e_dstM_i,
    input  logic        M_bubble_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [63:0] dmem_rdata_i,
    output logic        m_stall_o,
    output logic [2:0]  m_stat_o,
    output logic [3:0]  M_icode_o,
    output logic        M_cnd_o,
    output logic [63:0] M_valA_o,
    output logic [63:0] M_valE_o,
    output logic [3:0]  M_dstE_o,
    output logic [3:0]  M_dstM_o,
    output logic [63:0] m_valM_o,
    output logic [2:0]  W_stat_o,
    output logic [3:0]  W_icode_o,
    output logic [63:0] W_valE_o,
    output logic [63:0] W_valM_o,
    output logic [3:0]  W_dstE_o,
    output logic [3:0]  W_dstM_o
);

    localparam logic [WORD_W-1:0] ADDR_MAX = WORD_W'(MEM_BYTES - 8);

    m_reg_t M_q, M_d;
    w_reg_t W_q, W_d;

    logic              mem_rd, mem_wr, mem_op;
    logic [WORD_W-1:0] mem_addr;
    logic              addr_ok;
    logic              access;
    logic              timeout;

    // M register freezes while the memory port is stalled.
    always_comb begin
        M_d = M_q;
        if (!m_stall_o) begin
            if (M_bubble_i) begin
                M_d = M_BUBBLE;
            end else begin
                M_d = '{stat: e_stat_i, icode: e_icode_i, cnd: e_cnd_i,
                        val_e: e_valE_i, val_a: e_valA_i,
                        dst_e: e_dstE_i, dst_m: e_dstM_i};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            M_q <= M_BUBBLE;
            W_q <= W_BUBBLE;
        end else begin
            M_q <= M_d;
            W_q <= W_d;
        end
    end

    assign mem_rd   = is_mem_read(M_q.icode);
    assign mem_wr   = is_mem_write(M_q.icode);
    assign mem_op   = mem_rd || mem_wr;
    assign mem_addr = addr_from_val_a(M_q.icode) ? M_q.val_a : M_q.val_e;
    assign addr_ok  = (mem_addr <= ADDR_MAX);

    // A faulted instruction in W blocks younger accesses, so nothing past an
    // exception can modify memory.
    assign access = mem_op && (M_q.stat == SAOK) && (W_q.stat == SAOK) && addr_ok;

    dmem_port_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_port (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .access_i    (access),
        .ack_i       (dmem_ack_i),
        .req_c_o     (dmem_req_o),
        .stall_c_o   (m_stall_o),
        .timeout_c_o (timeout)
    );

    assign dmem_we_o    = dmem_req_o && mem_wr;
    assign dmem_addr_o  = dmem_req_o ? mem_addr : '0;
    assign dmem_wdata_o = (dmem_req_o && mem_wr) ? M_q.val_a : '0;

    assign m_valM_o = (dmem_req_o && dmem_ack_i && mem_rd) ? dmem_rdata_i : '0;
    assign m_stat_o = (timeout || (mem_op && !addr_ok)) ? SADR : M_q.stat;

    always_comb begin
        W_d = W_BUBBLE;
        if (!m_stall_o) begin
            W_d = '{stat: m_stat_o, icode: M_q.icode, val_e: M_q.val_e,
                    val_m: m_valM_o, dst_e: M_q.dst_e, dst_m: M_q.dst_m};
        end
    end

    assign M_icode_o = M_q.icode;
    assign M_cnd_o   = M_q.cnd;
    assign M_valA_o  = M_q.val_a;
    assign M_valE_o  = M_q.val_e;
    assign M_dstE_o  = M_q.dst_e;
    assign M_dstM_o  = M_q.dst_m;

    assign W_stat_o  = W_q.stat;
    assign W_icode_o = W_q.icode;
    assign W_valE_o  = W_q.val_e;
    assign W_valM_o  = W_q.val_m;
    assign W_dstE_o  = W_q.dst_e;
    assign W_dstM_o  = W_q.dst_m;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: reset, zero-wait and waited accesses,
// address fault, timeout abort, non-memory forwarding and reset during WAIT.
module tb_memory_access;
    import y86_defs::*;

    localparam int unsigned MEM_BYTES = 8192;
    localparam int unsigned TIMEOUT   = 255;

    logic        clk_i, rst_n_i;
    logic [2:0]  e_stat_i;
    logic [3:0]  e_icode_i;
    logic        e_cnd_i;
    logic [63:0] e_valE_i, e_valA_i;
    logic [3:0]  e_dstE_i, e_dstM_i;
    logic        M_bubble_i;
    logic        dmem_req_o, dmem_we_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_ack_i;
    logic [63:0] dmem_rdata_i;
    logic        m_stall_o;
    logic [2:0]  m_stat_o;
    logic [3:0]  M_icode_o;
    logic        M_cnd_o;
    logic [63:0] M_valA_o, M_valE_o;
    logic [3:0]  M_dstE_o, M_dstM_o;
    logic [63:0] m_valM_o;
    logic [2:0]  W_stat_o;
    logic [3:0]  W_icode_o;
    logic [63:0] W_valE_o, W_valM_o;
    logic [3:0]  W_dstE_o, W_dstM_o;

    int n_cmp = 0;
    int n_err = 0;

    memory_access #(.MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .e_stat_i(e_stat_i), .e_icode_i(e_icode_i), .e_cnd_i(e_cnd_i),
        .e_valE_i(e_valE_i), .e_valA_i(e_valA_i),
        .e_dstE_i(e_dstE_i), .e_dstM_i(e_dstM_i),
        .M_bubble_i(M_bubble_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .m_stall_o(m_stall_o), .m_stat_o(m_stat_o),
        .M_icode_o(M_icode_o), .M_cnd_o(M_cnd_o), .M_valA_o(M_valA_o),
        .M_valE_o(M_valE_o), .M_dstE_o(M_dstE_o), .M_dstM_o(M_dstM_o),
        .m_valM_o(m_valM_o),
        .W_stat_o(W_stat_o), .W_icode_o(W_icode_o),
        .W_valE_o(W_valE_o), .W_valM_o(W_valM_o),
        .W_dstE_o(W_dstE_o), .W_dstM_o(W_dstM_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_e(input logic [2:0] stat, input logic [3:0] icode,
                         input logic [63:0] val_e, input logic [63:0] val_a,
                         input logic [3:0] dst_e, input logic [3:0] dst_m);
        e_stat_i  = stat;
        e_icode_i = icode;
        e_cnd_i   = 1'b0;
        e_valE_i  = val_e;
        e_valA_i  = val_a;
        e_dstE_i  = dst_e;
        e_dstM_i  = dst_m;
    endtask

    task automatic set_nop();
        set_e(SAOK, I_NOP, 64'h0, 64'h0, RNONE, RNONE);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int n;
        set_nop();
        M_bubble_i   = 1'b0;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 64'h0;
        rst_n_i      = 1'b1;

        // Asynchronous reset mid-cycle
        #12 rst_n_i = 1'b0;
        #1;
        check_eq("rst_req",     64'(dmem_req_o), 64'd0);
        check_eq("rst_W_icode", 64'(W_icode_o),  64'(I_NOP));
        check_eq("rst_W_dstE",  64'(W_dstE_o),   64'hF);
        check_eq("rst_W_stat",  64'(W_stat_o),   64'(SAOK));
        check_eq("rst_W_valE",  W_valE_o,        64'h0);
        tick();
        rst_n_i = 1'b1;

        // Zero-wait read
        set_e(SAOK, I_MRMOVQ, 64'h100, 64'h0, RNONE, 4'd5);
        tick();
        set_nop();
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 64'h55;
        #1;
        check_eq("zr_req",   64'(dmem_req_o), 64'd1);
        check_eq("zr_we",    64'(dmem_we_o),  64'd0);
        check_eq("zr_addr",  dmem_addr_o,     64'h100);
        check_eq("zr_stall", 64'(m_stall_o),  64'd0);
        check_eq("zr_valM",  m_valM_o,        64'h55);
        tick();
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 64'h0;
        check_eq("zr_W_valM",  W_valM_o,        64'h55);
        check_eq("zr_W_dstM",  64'(W_dstM_o),   64'd5);
        check_eq("zr_W_icode", 64'(W_icode_o),  64'(I_MRMOVQ));

        // Write at the highest legal address
        set_e(SAOK, I_RMMOVQ, 64'(MEM_BYTES - 8), 64'h77, RNONE, RNONE);
        tick();
        set_nop();
        dmem_ack_i = 1'b1;
        #1;
        check_eq("bw_req",   64'(dmem_req_o), 64'd1);
        check_eq("bw_we",    64'(dmem_we_o),  64'd1);
        check_eq("bw_wdata", dmem_wdata_o,    64'h77);
        check_eq("bw_mstat", 64'(m_stat_o),   64'(SAOK));
        tick();
        dmem_ack_i = 1'b0;
        check_eq("bw_W_stat", 64'(W_stat_o), 64'(SAOK));

        // PUSHQ with three wait cycles; a bubble request mid-stall is ignored
        set_e(SAOK, I_PUSHQ, 64'h1F8, 64'hAB, 4'd4, RNONE);
        tick();
        set_nop();
        for (int i = 0; i < 3; i++) begin
            M_bubble_i = (i == 1);
            #1;
            check_eq("ww_stall", 64'(m_stall_o),  64'd1);
            check_eq("ww_addr",  dmem_addr_o,     64'h1F8);
            check_eq("ww_wdata", dmem_wdata_o,    64'hAB);
            check_eq("ww_we",    64'(dmem_we_o),  64'd1);
            tick();
            check_eq("ww_W_bubble", 64'(W_icode_o), 64'(I_NOP));
            check_eq("ww_W_dstE",   64'(W_dstE_o),  64'hF);
        end
        M_bubble_i = 1'b0;
        dmem_ack_i = 1'b1;
        #1;
        check_eq("ww_ack_stall", 64'(m_stall_o),  64'd0);
        check_eq("ww_ack_req",   64'(dmem_req_o), 64'd1);
        check_eq("ww_ack_addr",  dmem_addr_o,     64'h1F8);
        tick();
        dmem_ack_i = 1'b0;
        check_eq("ww_W_icode", 64'(W_icode_o), 64'(I_PUSHQ));
        check_eq("ww_W_valE",  W_valE_o,       64'h1F8);
        check_eq("ww_W_dstE",  64'(W_dstE_o),  64'd4);

        // Address fault, then a younger PUSHQ must not reach memory
        set_e(SAOK, I_RMMOVQ, 64'(MEM_BYTES - 7), 64'h1, RNONE, RNONE);
        tick();
        set_e(SAOK, I_PUSHQ, 64'h100, 64'h2, 4'd4, RNONE);
        #1;
        check_eq("af_req",   64'(dmem_req_o), 64'd0);
        check_eq("af_mstat", 64'(m_stat_o),   64'(SADR));
        check_eq("af_stall", 64'(m_stall_o),  64'd0);
        tick();
        set_nop();
        #1;
        check_eq("af_W_stat",  64'(W_stat_o),   64'(SADR));
        check_eq("af_W_icode", 64'(W_icode_o),  64'(I_RMMOVQ));
        check_eq("af_push_req", 64'(dmem_req_o), 64'd0);
        check_eq("af_push_we",  64'(dmem_we_o),  64'd0);
        tick();
        check_eq("af_push_W_icode", 64'(W_icode_o), 64'(I_PUSHQ));

        // POPQ never acked: aborts after TIMEOUT stalled cycles
        set_e(SAOK, I_POPQ, 64'h208, 64'h200, 4'd4, 4'd3);
        tick();
        set_nop();
        #1;
        check_eq("to_addr", dmem_addr_o,    64'h200);
        check_eq("to_we",   64'(dmem_we_o), 64'd0);
        n = 0;
        while (m_stall_o === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        check_eq("to_stall_cycles", 64'(n),          64'(TIMEOUT));
        check_eq("to_req_drop",     64'(dmem_req_o), 64'd0);
        check_eq("to_mstat",        64'(m_stat_o),   64'(SADR));
        check_eq("to_valM",         m_valM_o,        64'h0);
        tick();
        check_eq("to_W_stat",  64'(W_stat_o),  64'(SADR));
        check_eq("to_W_icode", 64'(W_icode_o), 64'(I_POPQ));
        tick();
        set_e(SAOK, I_MRMOVQ, 64'h40, 64'h0, RNONE, 4'd6);
        tick();
        set_nop();
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 64'h99;
        #1;
        check_eq("to_idle_req",   64'(dmem_req_o), 64'd1);
        check_eq("to_idle_stall", 64'(m_stall_o),  64'd0);
        tick();
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 64'h0;
        check_eq("to_idle_W_valM", W_valM_o, 64'h99);

        // Non-memory op forwarding and writeback
        set_e(SAOK, I_OPQ, 64'h7, 64'h0, 4'd3, RNONE);
        tick();
        set_nop();
        #1;
        check_eq("op_M_valE",  M_valE_o,        64'h7);
        check_eq("op_M_dstE",  64'(M_dstE_o),   64'd3);
        check_eq("op_M_icode", 64'(M_icode_o),  64'(I_OPQ));
        check_eq("op_req",     64'(dmem_req_o), 64'd0);
        tick();
        check_eq("op_W_valE",  W_valE_o,       64'h7);
        check_eq("op_W_dstE",  64'(W_dstE_o),  64'd3);
        check_eq("op_W_icode", 64'(W_icode_o), 64'(I_OPQ));

        // Bubble injection when not stalled
        set_e(SAOK, I_OPQ, 64'h9, 64'h0, 4'd2, RNONE);
        M_bubble_i = 1'b1;
        tick();
        M_bubble_i = 1'b0;
        set_nop();
        check_eq("bub_M_icode", 64'(M_icode_o), 64'(I_NOP));
        check_eq("bub_M_dstE",  64'(M_dstE_o),  64'hF);
        check_eq("bub_M_valE",  M_valE_o,       64'h0);

        // Reset while waiting abandons the request at once
        set_e(SAOK, I_MRMOVQ, 64'h80, 64'h0, RNONE, 4'd1);
        tick();
        set_nop();
        #1;
        check_eq("rw_stall", 64'(m_stall_o), 64'd1);
        tick();
        #2 rst_n_i = 1'b0;
        #1;
        check_eq("rw_req",     64'(dmem_req_o), 64'd0);
        check_eq("rw_stall0",  64'(m_stall_o),  64'd0);
        check_eq("rw_M_icode", 64'(M_icode_o),  64'(I_NOP));
        tick();
        rst_n_i = 1'b1;
        tick();
        check_eq("rw_after_req", 64'(dmem_req_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
